// File: rtl/i281_exec_sequencer_if.sv
// Control/status bundle between the i281 sequencer, the datapath and the program loader.
interface i281_exec_sequencer_if #(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned CNT_W = 16
);
    logic             cmd_run;
    logic             cmd_step;
    logic             cmd_halt;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             ld_req;
    logic             ld_done;
    logic             ld_gnt;
    logic             cpu_en;
    logic [2:0]       state;
    logic             bp_hit;
    logic [CNT_W-1:0] retired;

    // Side that issues commands and observes the sequencer.
    modport master (
        output cmd_run, cmd_step, cmd_halt, bp_en, bp_addr, pc, ld_req, ld_done,
        input  ld_gnt, cpu_en, state, bp_hit, retired
    );

    // The sequencer itself.
    modport slave (
        input  cmd_run, cmd_step, cmd_halt, bp_en, bp_addr, pc, ld_req, ld_done,
        output ld_gnt, cpu_en, state, bp_hit, retired
    );
endinterface

// File: rtl/i281_exec_sequencer.sv
// Run/step/halt sequencer for the i281 single-cycle datapath: produces the commit qualifier
// cpu_en, arbitrates memory ownership with the program loader, implements a PC breakpoint
// and a saturating retired-instruction counter.
module i281_exec_sequencer #(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    i281_exec_sequencer_if.slave  bus_io
);

    typedef enum logic [2:0] {
        StHalt  = 3'd0,
        StRun   = 3'd1,
        StStep  = 3'd2,
        StBreak = 3'd3,
        StLoad  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RetMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RetOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic             skip_q;
    logic             ld_gnt_q;
    logic             bp_hit_q;
    logic [CNT_W-1:0] retired_q;

    logic             bp_match;
    logic             cpu_en;

    // skip_q masks the breakpoint on the first RUN cycle so a run started at bp_addr
    // executes that instruction instead of re-breaking immediately.
    always_comb begin
        bp_match = bus_io.bp_en && (bus_io.pc == bus_io.bp_addr) && !skip_q;
        cpu_en   = (state_q == StStep) || ((state_q == StRun) && !bp_match);
    end

    // Sequencer FSM with registered grant, breakpoint flag and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHalt;
            skip_q    <= 1'b0;
            ld_gnt_q  <= 1'b0;
            bp_hit_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            if (cpu_en && (retired_q != RetMax)) begin
                retired_q <= retired_q + RetOne;
            end
            unique case (state_q)
                StHalt: begin
                    if (bus_io.ld_req) begin
                        state_q  <= StLoad;
                        ld_gnt_q <= 1'b1;
                    end else if (bus_io.cmd_step) begin
                        state_q  <= StStep;
                        bp_hit_q <= 1'b0;
                    end else if (bus_io.cmd_run) begin
                        state_q  <= StRun;
                        skip_q   <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end
                end
                StRun: begin
                    skip_q <= 1'b0;
                    if (bus_io.cmd_halt) begin
                        state_q <= StHalt;
                    end else if (bp_match) begin
                        state_q  <= StBreak;
                        bp_hit_q <= 1'b1;
                    end
                end
                StStep: begin
                    state_q <= StHalt;
                end
                StBreak: begin
                    if (bus_io.cmd_halt) begin
                        state_q <= StHalt;
                    end else if (bus_io.ld_req) begin
                        state_q  <= StLoad;
                        ld_gnt_q <= 1'b1;
                    end else if (bus_io.cmd_step) begin
                        state_q  <= StStep;
                        bp_hit_q <= 1'b0;
                    end else if (bus_io.cmd_run) begin
                        state_q  <= StRun;
                        skip_q   <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end
                end
                StLoad: begin
                    // A completed load invalidates the old program's statistics.
                    if (bus_io.ld_done) begin
                        state_q   <= StHalt;
                        ld_gnt_q  <= 1'b0;
                        retired_q <= '0;
                        bp_hit_q  <= 1'b0;
                    end else if (!bus_io.ld_req) begin
                        state_q  <= StHalt;
                        ld_gnt_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StHalt;
                    ld_gnt_q <= 1'b0;
                    skip_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.cpu_en  = cpu_en;
    assign bus_io.ld_gnt  = ld_gnt_q;
    assign bus_io.state   = state_q;
    assign bus_io.bp_hit  = bp_hit_q;
    assign bus_io.retired = retired_q;

endmodule

// File: tb/tb_i281_exec_sequencer.sv
// Scoreboard bench for i281_exec_sequencer: a driver issues stimulus and pushes the
// reference model's expected outputs; a negedge monitor pops and compares. Two DUTs share
// the stimulus, one with a 16-bit and one with a 4-bit retired counter.
module tb_i281_exec_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cmd_run, cmd_step, cmd_halt, bp_en, ld_req, ld_done;
    logic [4:0] bp_addr, pc;

    i281_exec_sequencer_if #(.PC_W(5), .CNT_W(16)) bus16 ();
    i281_exec_sequencer_if #(.PC_W(5), .CNT_W(4))  bus4 ();

    assign bus16.cmd_run  = cmd_run;
    assign bus16.cmd_step = cmd_step;
    assign bus16.cmd_halt = cmd_halt;
    assign bus16.bp_en    = bp_en;
    assign bus16.bp_addr  = bp_addr;
    assign bus16.pc       = pc;
    assign bus16.ld_req   = ld_req;
    assign bus16.ld_done  = ld_done;
    assign bus4.cmd_run   = cmd_run;
    assign bus4.cmd_step  = cmd_step;
    assign bus4.cmd_halt  = cmd_halt;
    assign bus4.bp_en     = bp_en;
    assign bus4.bp_addr   = bp_addr;
    assign bus4.pc        = pc;
    assign bus4.ld_req    = ld_req;
    assign bus4.ld_done   = ld_done;

    i281_exec_sequencer #(.PC_W(5), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus_io(bus16));
    i281_exec_sequencer #(.PC_W(5), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus_io(bus4));

    typedef struct {
        int st;
        int en;
        int gnt;
        int hit;
        int r16;
        int r4;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model (state codes: 0 halt, 1 run, 2 step, 3 break, 4 load).
    int m_st, m_skip, m_gnt, m_hit, m_r16, m_r4;

    task automatic model_reset();
        m_st = 0; m_skip = 0; m_gnt = 0; m_hit = 0; m_r16 = 0; m_r4 = 0;
    endtask

    task automatic go_run();
        m_st = 1; m_skip = 1; m_hit = 0;
    endtask

    task automatic go_step();
        m_st = 2; m_hit = 0;
    endtask

    // One clock cycle: record what the DUT must show now, advance the model, take the edge.
    task automatic tick();
        exp_t e;
        int   en;
        int   at_bp;
        at_bp = (bp_en && (pc == bp_addr) && (m_skip == 0)) ? 1 : 0;
        en    = (m_st == 2 || (m_st == 1 && at_bp == 0)) ? 1 : 0;
        e.st = m_st; e.en = en; e.gnt = m_gnt; e.hit = m_hit; e.r16 = m_r16; e.r4 = m_r4;
        q.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            if (en == 1) begin
                if (m_r16 < 65535) m_r16++;
                if (m_r4 < 15) m_r4++;
            end
            case (m_st)
                0: begin
                    if (ld_req) m_st = 4;
                    else if (cmd_step) go_step();
                    else if (cmd_run) go_run();
                end
                1: begin
                    m_skip = 0;
                    if (cmd_halt) m_st = 0;
                    else if (en == 0) begin m_st = 3; m_hit = 1; end
                end
                2: m_st = 0;
                3: begin
                    if (cmd_halt) m_st = 0;
                    else if (ld_req) m_st = 4;
                    else if (cmd_step) go_step();
                    else if (cmd_run) go_run();
                end
                default: begin
                    if (ld_done) begin m_st = 0; m_r16 = 0; m_r4 = 0; m_hit = 0; end
                    else if (!ld_req) m_st = 0;
                end
            endcase
            m_gnt = (m_st == 4) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (en == 1) pc = pc + 5'd1;
        cmd_run = 0; cmd_step = 0; cmd_halt = 0; ld_done = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Monitor: every cycle is an output beat; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",    int'(bus16.state),   e.st);
            chk("cpu_en",   int'(bus16.cpu_en),  e.en);
            chk("ld_gnt",   int'(bus16.ld_gnt),  e.gnt);
            chk("bp_hit",   int'(bus16.bp_hit),  e.hit);
            chk("retired",  int'(bus16.retired), e.r16);
            chk("state_w4", int'(bus4.state),    e.st);
            chk("ret_w4",   int'(bus4.retired),  e.r4);
            chk("gnt_en_excl", int'(bus16.ld_gnt & bus16.cpu_en), 0);
        end
    end

    initial begin
        cmd_run = 0; cmd_step = 0; cmd_halt = 0; ld_done = 0; ld_req = 0;
        bp_en = 0; bp_addr = 0; pc = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;

        // Reset state; halt alone is a no-op.
        tick();
        cmd_halt = 1; tick();
        tick();

        // Single step, then run+step together resolves to step.
        cmd_step = 1; tick();
        repeat (2) tick();
        cmd_run = 1; cmd_step = 1; tick();
        repeat (2) tick();

        // Breakpoint at 5 from pc 0, then resume from the breakpoint.
        pc = 0; bp_en = 1; bp_addr = 5;
        cmd_run = 1; tick();
        repeat (7) tick();
        cmd_run = 1; tick();
        repeat (3) tick();
        cmd_halt = 1; tick();
        tick();

        // Halt while running commits the halting cycle.
        bp_en = 0;
        cmd_run = 1; tick();
        repeat (3) tick();
        cmd_halt = 1; tick();
        repeat (2) tick();

        // Loader: no grant while running, grant after halt, done clears counters.
        cmd_run = 1; tick();
        ld_req = 1; repeat (3) tick();
        cmd_halt = 1; tick();
        repeat (3) tick();
        ld_done = 1; tick();
        ld_req = 0; repeat (2) tick();
        ld_req = 1; repeat (3) tick();
        rst = 1; ld_req = 0; tick();
        rst = 0; repeat (2) tick();
        ld_req = 1; repeat (2) tick();
        ld_req = 0; repeat (2) tick();

        // Saturation of the narrow counter.
        cmd_run = 1; tick();
        repeat (22) tick();
        cmd_halt = 1; tick();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cmd_run  = (r < 10);
            cmd_step = (r >= 10 && r < 16);
            cmd_halt = (r >= 16 && r < 22);
            if ($urandom_range(0, 19) == 0) ld_req = ~ld_req;
            ld_done = ld_req && ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 29) == 0) bp_addr = 5'($urandom_range(0, 31));
            tick();
            rst = 0;
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
